// File: rtl/sram_data_responder_if.sv
// sram_data_responder_if: core data-side SRAM bus (request from core, registered read data back)
interface sram_data_responder_if;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rdata_valid;

    modport master (
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, rdata_valid
    );

    modport slave (
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, rdata_valid
    );
endinterface

// File: rtl/sram_data_responder.sv
// sram_data_responder: data SRAM slave serving a byte-writable RAM plus an LED/switch/timer MMIO page
module sram_data_responder #(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000,
    parameter logic [15:0] LED_RST   = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_data_responder_if.slave bus,
    input  logic [7:0]           switch,
    output logic [15:0]          led,
    output logic                 timer_int
);
    logic [31:0]       ram [2**RAM_AW];
    logic [31:0]       ramQ, mmioQ, count, compare, mmioRd;
    logic              srcRam, pending, rd, wr, isRam, isMmio, hit, clr;
    logic              wLed, wCount, wCmp, wStat;
    logic [RAM_AW-1:0] idx;
    logic [9:0]        word;
    logic              unusedAddr;

    // Virtual-address bits 31:29 and the byte offset never affect decode.
    assign unusedAddr = ^{bus.mem_addr[31:29], bus.mem_addr[1:0]};
    assign rd     = bus.mem_en & ~|bus.mem_wen;
    assign wr     = bus.mem_en & |bus.mem_wen;
    assign isRam  = bus.mem_addr[28:RAM_AW+2] == '0;
    assign isMmio = bus.mem_addr[28:12] == MMIO_BASE[28:12];
    assign idx    = bus.mem_addr[RAM_AW+1:2];
    assign word   = bus.mem_addr[11:2];
    assign wLed   = wr & isMmio & (word == 10'd0);
    assign wCount = wr & isMmio & (word == 10'd2);
    assign wCmp   = wr & isMmio & (word == 10'd3);
    assign wStat  = wr & isMmio & (word == 10'd4);
    assign hit    = (count == compare) && (compare != 32'd0);
    assign clr    = wCmp | (wStat & bus.mem_wen[0] & bus.mem_wdata[0]);
    assign mmioRd = word == 10'd0 ? {16'h0, led} :
                    word == 10'd1 ? {24'h0, switch} :
                    word == 10'd2 ? count :
                    word == 10'd3 ? compare :
                    word == 10'd4 ? {31'h0, pending} : 32'h0;
    assign bus.mem_rdata = srcRam ? ramQ : mmioQ;
    assign timer_int     = pending;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        for (int b = 0; b < 4; b++) merge[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    endfunction

    // RAM port: read-first registered read and byte-lane writes, unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (rd & isRam) ramQ <= ram[idx];
        for (int b = 0; b < 4; b++) if (wr & isRam & bus.mem_wen[b]) ram[idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end

    // Read response, MMIO registers and timer; set of pending wins over any clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata_valid <= 1'b0;
            srcRam          <= 1'b0;
            mmioQ           <= 32'h0;
            led             <= LED_RST;
            count           <= 32'h0;
            compare         <= 32'h0;
            pending         <= 1'b0;
        end else begin
            bus.rdata_valid <= rd;
            if (rd) begin
                srcRam <= isRam;
                mmioQ  <= isMmio ? mmioRd : 32'h0;
            end
            if (wLed & bus.mem_wen[0]) led[7:0] <= bus.mem_wdata[7:0];
            if (wLed & bus.mem_wen[1]) led[15:8] <= bus.mem_wdata[15:8];
            count <= wCount ? merge(count, bus.mem_wdata, bus.mem_wen) : count + 32'd1;
            if (wCmp) compare <= merge(compare, bus.mem_wdata, bus.mem_wen);
            pending <= hit | (pending & ~clr);
        end
    end
endmodule

// File: tb/tb_sram_data_responder.sv
// tb_sram_data_responder: vector table, timer/reset sequences and random traffic against a reference model
module tb_sram_data_responder;
    localparam int          AW   = 14;
    localparam logic [31:0] BASE = 32'h1FAF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sw = 8'h00;
    logic [15:0] led;
    logic        timerInt;
    int          nCmp = 0;
    int          nBad = 0;

    sram_data_responder_if bus();

    sram_data_responder #(.RAM_AW(AW), .MMIO_BASE(BASE), .LED_RST(16'h0000)) dut (
        .clk(clk), .rst(rst), .bus(bus), .switch(sw), .led(led), .timer_int(timerInt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state as the bus sees it
    logic [31:0] mram [int];
    logic [15:0] mLed;
    logic [31:0] mCount, mCmp, mRdata;
    logic        mPend, mValid, mKnown;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic [31:0] expRdata;
        logic        expValid;
        logic [15:0] expLed;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic modelReset();
        mLed = 16'h0; mCount = 0; mCmp = 0; mPend = 0; mRdata = 0; mValid = 0; mKnown = 1;
    endtask

    // Drive one bus cycle from a negedge, advance the model, check after the edge, return at the next negedge
    task automatic apply(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] pa, nCount, t;
        logic [11:0] off;
        int          idx;
        bit          isRam, isMmio, rd, wr, hit, clr;
        bus.mem_en = en; bus.mem_wen = wen; bus.mem_addr = addr; bus.mem_wdata = wdata;
        pa     = {3'b000, addr[28:0]};
        isRam  = pa < (32'd4 << AW);
        isMmio = pa[28:12] == BASE[28:12];
        idx    = int'(pa >> 2);
        off    = {pa[11:2], 2'b00};
        rd     = en && wen == 4'h0;
        wr     = en && wen != 4'h0;
        hit    = mCount == mCmp && mCmp != 0;
        clr    = 0;
        mValid = rd;
        if (rd) begin
            mKnown = 1;
            if (isRam) begin
                if (mram.exists(idx)) mRdata = mram[idx];
                else mKnown = 0;
            end else if (isMmio) begin
                case (off)
                    12'h000: mRdata = {16'h0, mLed};
                    12'h004: mRdata = {24'h0, sw};
                    12'h008: mRdata = mCount;
                    12'h00C: mRdata = mCmp;
                    12'h010: mRdata = {31'h0, mPend};
                    default: mRdata = 0;
                endcase
            end else mRdata = 0;
        end
        nCount = mCount + 1;
        if (wr && isRam) mram[idx] = bmerge(mram.exists(idx) ? mram[idx] : 32'h0, wdata, wen);
        else if (wr && isMmio) begin
            case (off)
                12'h000: begin t = bmerge({16'h0, mLed}, wdata, wen); mLed = t[15:0]; end
                12'h008: nCount = bmerge(mCount, wdata, wen);
                12'h00C: begin mCmp = bmerge(mCmp, wdata, wen); clr = 1; end
                12'h010: clr = wen[0] && wdata[0];
                default: ;
            endcase
        end
        mCount = nCount;
        mPend  = hit ? 1'b1 : clr ? 1'b0 : mPend;
        @(posedge clk);
        #1;
        chk("model_valid", {31'h0, bus.rdata_valid}, {31'h0, mValid});
        if (mKnown) chk("model_rdata", bus.mem_rdata, mRdata);
        chk("model_led", {16'h0, led}, {16'h0, mLed});
        chk("model_timer", {31'h0, timerInt}, {31'h0, mPend});
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  w;
        logic        e;
        int          s;
        bus.mem_en = 0; bus.mem_wen = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
        modelReset();
        repeat (2) @(negedge clk);
        chk("reset_rdata", bus.mem_rdata, 32'h0);
        chk("reset_valid", {31'h0, bus.rdata_valid}, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_timer", {31'h0, timerInt}, 32'h0);
        rst = 0;

        vecs.push_back('{1'b1, 4'hF, 32'h0000_0010, 32'hAABB_CCDD, 8'hC3, 32'h0000_0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 4'h1, 32'h0000_0010, 32'h0000_0011, 8'hC3, 32'h0000_0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 4'h0, 32'h8000_0010, 32'h0,         8'hC3, 32'hAABB_CC11, 1'b1, 16'h0000});
        vecs.push_back('{1'b0, 4'h0, 32'h0,         32'h0,         8'hC3, 32'hAABB_CC11, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 4'h0, 32'h0000_0010, 32'h0,         8'hC3, 32'hAABB_CC11, 1'b1, 16'h0000});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 8'hC3, 32'hAABB_CC11, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 4'h0, 32'h0000_0010, 32'h0,         8'hC3, 32'h1234_5678, 1'b1, 16'h0000});
        vecs.push_back('{1'b1, 4'h0, 32'h0800_0000, 32'h0,         8'hC3, 32'h0000_0000, 1'b1, 16'h0000});
        vecs.push_back('{1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_5A5A, 8'hC3, 32'h0000_0000, 1'b0, 16'h5A5A});
        vecs.push_back('{1'b1, 4'h0, 32'hBFAF_0004, 32'h0,         8'hC3, 32'h0000_00C3, 1'b1, 16'h5A5A});
        vecs.push_back('{1'b1, 4'h2, 32'hBFAF_0000, 32'h0000_A500, 8'hC3, 32'h0000_00C3, 1'b0, 16'hA55A});
        vecs.push_back('{1'b1, 4'h0, 32'hBFAF_0000, 32'h0,         8'hC3, 32'h0000_A55A, 1'b1, 16'hA55A});
        vecs.push_back('{1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFF, 8'hC3, 32'h0000_A55A, 1'b0, 16'hA55A});
        vecs.push_back('{1'b1, 4'h0, 32'hBFAF_0014, 32'h0,         8'hC3, 32'h0000_0000, 1'b1, 16'hA55A});
        vecs.push_back('{1'b1, 4'hF, 32'h0800_0000, 32'hDEAD_BEEF, 8'hC3, 32'h0000_0000, 1'b0, 16'hA55A});
        vecs.push_back('{1'b1, 4'h0, 32'h0800_0000, 32'h0,         8'hC3, 32'h0000_0000, 1'b1, 16'hA55A});
        vecs.push_back('{1'b0, 4'hF, 32'h0000_0010, 32'h0,         8'hC3, 32'h0000_0000, 1'b0, 16'hA55A});
        vecs.push_back('{1'b1, 4'h0, 32'h0000_0010, 32'h0,         8'hC3, 32'h1234_5678, 1'b1, 16'hA55A});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_FFFC, 32'hCAFE_F00D, 8'hC3, 32'h1234_5678, 1'b0, 16'hA55A});
        vecs.push_back('{1'b1, 4'h0, 32'h0001_0000, 32'h0,         8'hC3, 32'h0000_0000, 1'b1, 16'hA55A});
        vecs.push_back('{1'b1, 4'h0, 32'hE000_FFFC, 32'h0,         8'hC3, 32'hCAFE_F00D, 1'b1, 16'hA55A});
        vecs.push_back('{1'b1, 4'h0, 32'hBFAF_0003, 32'h0,         8'h5C, 32'h0000_A55A, 1'b1, 16'hA55A});
        foreach (vecs[i]) begin
            sw = vecs[i].sw;
            apply(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), bus.mem_rdata, vecs[i].expRdata);
            chk($sformatf("vec%0d_valid", i), {31'h0, bus.rdata_valid}, {31'h0, vecs[i].expValid});
            chk($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].expLed});
        end

        apply(1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE);
        apply(1, 4'hF, 32'hBFAF_000C, 32'h0000_0003);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("timer_before_hit", {31'h0, timerInt}, 32'h0);
        end
        idle();
        chk("timer_hit", {31'h0, timerInt}, 32'h1);
        apply(1, 4'h0, 32'hBFAF_0010, 32'h0);
        chk("status_read", bus.mem_rdata, 32'h1);
        apply(1, 4'h1, 32'hBFAF_0010, 32'h1);
        chk("status_w1c", {31'h0, timerInt}, 32'h0);

        apply(1, 4'hF, 32'hBFAF_000C, 32'h0);
        apply(1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFD);
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("compare_zero_quiet", {31'h0, timerInt}, 32'h0);
        end

        apply(1, 4'hF, 32'hBFAF_000C, 32'd10);
        apply(1, 4'hF, 32'hBFAF_0008, 32'd8);
        idle();
        idle();
        apply(1, 4'h1, 32'hBFAF_0010, 32'h1);
        chk("set_beats_clear", {31'h0, timerInt}, 32'h1);
        apply(1, 4'hF, 32'hBFAF_000C, 32'h100);
        chk("compare_write_clears", {31'h0, timerInt}, 32'h0);

        for (int i = 0; i < 8; i++) apply(1, 4'hF, 32'h100 + 32'(i * 4), $urandom);
        for (int i = 0; i < 400; i++) begin
            s = $urandom_range(0, 9);
            a = s < 5 ? 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)) :
                s < 9 ? 32'h1FAF_0000 + 32'($urandom_range(0, 6) << 2) :
                        32'h0800_0000 + 32'($urandom_range(0, 255));
            a[31:29] = 3'($urandom);
            e = $urandom_range(0, 3) != 0;
            w = $urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom);
            d = $urandom_range(0, 1) != 0 ? 32'($urandom_range(0, 40)) : $urandom;
            sw = 8'($urandom);
            apply(e, w, a, d);
        end

        apply(1, 4'h3, 32'hBFAF_0000, 32'h0000_1234);
        bus.mem_en = 1; bus.mem_wen = 0; bus.mem_addr = 32'h0000_0010;
        #2 rst = 1;
        #1;
        chk("async_rst_rdata", bus.mem_rdata, 32'h0);
        chk("async_rst_valid", {31'h0, bus.rdata_valid}, 32'h0);
        chk("async_rst_led", {16'h0, led}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", {31'h0, bus.rdata_valid}, 32'h0);
        chk("rst_hold_rdata", bus.mem_rdata, 32'h0);
        @(negedge clk);
        rst = 0;
        modelReset();
        idle();
        chk("post_rst_valid", {31'h0, bus.rdata_valid}, 32'h0);
        apply(1, 4'h0, 32'hBFAF_0008, 32'h0);
        chk("count_after_rst", bus.mem_rdata, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
